// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding and default widths.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem_i, msb_i};

  // Partial remainder stays below the divisor, so the kept value always fits WIDTH bits
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/restoring_divider_sequential.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement truncating division; default is unsigned.
module restoring_divider_sequential
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q_bit;

`ifdef DIV_SIGNED_EN
  logic sa_q, sa_d;
  logic sq_q, sq_d;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a zero divisor skips the iteration entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (b == '0) ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next-values; dvd doubles as the quotient shift register
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    dz_d   = dz_q;
    busy_d = busy_q;
    done_d = 1'b0;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    dbz_d  = dbz_q;
`ifdef DIV_SIGNED_EN
    sa_d   = sa_q;
    sq_d   = sq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = CNT_W'(WIDTH - 1);
          dz_d   = (b == '0);
          busy_d = 1'b1;
`ifdef DIV_SIGNED_EN
          sa_d   = a[WIDTH-1];
          sq_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q_bit};
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        dbz_d  = dz_q;
`ifdef DIV_SIGNED_EN
        // Divide-by-zero rebuilds the original dividend from magnitude and sign
        if (dz_q) begin
          quo_d = '1;
          rmd_d = sa_q ? -dvd_q : dvd_q;
        end else begin
          quo_d = sq_q ? -dvd_q : dvd_q;
          rmd_d = sa_q ? -rem_q : rem_q;
        end
`else
        if (dz_q) begin
          quo_d = '1;
          rmd_d = dvd_q;
        end else begin
          quo_d = dvd_q;
          rmd_d = rem_q;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      sa_q   <= 1'b0;
      sq_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      dbz_q  <= dbz_d;
`ifdef DIV_SIGNED_EN
      sa_q   <= sa_d;
      sq_q   <= sq_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_sequential.sv
// Directed bench for restoring_divider_sequential (expectations follow DIV_SIGNED_EN).
module tb_restoring_divider_sequential;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total;
  int bad;

  restoring_divider_sequential #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept at edge 0, then count edges until done is seen (bounded)
  task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic seen, output logic busy0);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    seen = done;
    lat = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = done;
    end
  endtask

  initial begin
    int   lat;
    logic seen;
    logic busy0;
    int   ndone;
    int   dedge;
    int   dedges[$];

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0]  = '{"100/7",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{"div0",       32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1};
    vecs[2]  = '{"1000/10",    32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 33};
    vecs[3]  = '{"5/5",        32'd5,          32'd5,          32'd1,          32'd0,          1'b0, 33};
    vecs[4]  = '{"3/10",       32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33};
    vecs[5]  = '{"0/5",        32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[6]  = '{"ones/1",     32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[7]  = '{"ones/ones",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
    vecs[8]  = '{"min/0",      32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1};
`ifdef DIV_SIGNED_EN
    vecs[9]  = '{"min/-1",     32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[10] = '{"-7/2",       32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
    vecs[11] = '{"7/-2",       32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
`else
    vecs[9]  = '{"min/-1",     32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
    vecs[10] = '{"-7/2",       32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 33};
    vecs[11] = '{"7/-2",       32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,          1'b0, 33};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", W'(busy), 32'd0);
    chk("rst_done", W'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", W'(div_by_zero), 32'd0);

    // Table-driven single divides
    for (int i = 0; i < 12; i++) begin
      do_div(vecs[i].a, vecs[i].b, lat, seen, busy0);
      chk({vecs[i].name, "_busy_after_accept"}, W'(busy0), 32'd1);
      chk({vecs[i].name, "_done_seen"}, W'(seen), 32'd1);
      chk({vecs[i].name, "_latency"}, W'(lat), W'(vecs[i].lat));
      chk({vecs[i].name, "_q"}, quotient, vecs[i].q);
      chk({vecs[i].name, "_r"}, remainder, vecs[i].r);
      chk({vecs[i].name, "_dbz"}, W'(div_by_zero), W'(vecs[i].dz));
      chk({vecs[i].name, "_busy_at_done"}, W'(busy), 32'd0);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, W'(done), 32'd0);
      chk({vecs[i].name, "_q_held"}, quotient, vecs[i].q);
    end

    // Starts while busy (with new operands) must be ignored
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dedge = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        dedge = k;
        chk("ignore_q", quotient, 32'd14);
        chk("ignore_r", remainder, 32'd2);
      end
      start = (k == 4) || (k == 19);
      if (k == 4)  begin a = 32'd5; b = 32'd1; end
      if (k == 19) begin a = 32'd9; b = 32'd3; end
    end
    chk("ignore_ndone", W'(ndone), 32'd1);
    chk("ignore_edge", W'(dedge), 32'd33);

    // Abort: load non-zero results first, then reset mid-operation
    do_div(32'h55, 32'd0, lat, seen, busy0);
    chk("pre_abort_dbz", W'(div_by_zero), 32'd1);
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", W'(busy), 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_dbz", W'(div_by_zero), 32'd0);
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", W'(ndone), 32'd0);

    // Start held high: back-to-back jobs accepted in each done cycle
    @(negedge clk);
    a = 32'd1000; b = 32'd10; start = 1'b1;
    for (int k = 0; k <= 110; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dedges.push_back(k);
        chk("b2b_q", quotient, 32'd100);
        chk("b2b_r", remainder, 32'd0);
      end
    end
    start = 1'b0;
    chk("b2b_ndone", W'(dedges.size()), 32'd3);
    if (dedges.size() == 3) begin
      chk("b2b_first", W'(dedges[0]), 32'd33);
      chk("b2b_gap1", W'(dedges[1] - dedges[0]), 32'd34);
      chk("b2b_gap2", W'(dedges[2] - dedges[1]), 32'd34);
    end
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen = done;
    end
    chk("b2b_drain_done", W'(seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
